// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the three-way block-RAM port arbiter: FSM states,
// requester IDs, default geometry and the fixed-priority pick.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RID_IF  = 2'd0,
      RID_DM  = 2'd1,
      RID_DBG = 2'd2
   } req_id_e;

   // Loader beats data memory, data memory beats fetch.
   function automatic req_id_e pick_winner(input logic dbg_r, input logic dm_r);
      if (dbg_r)     return RID_DBG;
      else if (dm_r) return RID_DM;
      else           return RID_IF;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, data-memory and loader requests onto one synchronous
// block-RAM port; one transaction at a time, IDLE -> ACCESS -> RESP.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              if_done,
   output logic              dm_done,
   output logic              dbg_done,
   output logic [DATA_W-1:0] rdata_out,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   state_e            state_q, state_d;
   req_id_e           wid_q, wid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic              if_done_q, if_done_d;
   logic              dm_done_q, dm_done_d;
   logic              dbg_done_q, dbg_done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              any_req;

   assign any_req = if_req | dm_req | dbg_req;

   always_comb begin
      state_d    = state_q;
      wid_d      = wid_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      ram_en_d   = 1'b0;
      ram_we_d   = 1'b0;
      if_done_d  = 1'b0;
      dm_done_d  = 1'b0;
      dbg_done_d = 1'b0;
      rdata_d    = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               wid_d = pick_winner(dbg_req, dm_req);
               case (wid_d)
                  RID_DBG: begin
                     addr_d  = dbg_addr;
                     wdata_d = dbg_wdata;
                     we_d    = 1'b1;
                  end
                  RID_DM: begin
                     addr_d  = dm_addr;
                     wdata_d = dm_wdata;
                     we_d    = dm_we;
                  end
                  default: begin
                     addr_d  = if_addr;
                     wdata_d = '0;
                     we_d    = 1'b0;
                  end
               endcase
               // Port strobes are computed one cycle early so they leave a flop.
               ram_en_d = 1'b1;
               ram_we_d = we_d;
               state_d  = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if_done_d  = (wid_q == RID_IF);
            dm_done_d  = (wid_q == RID_DM);
            dbg_done_d = (wid_q == RID_DBG);
            state_d    = ST_RESP;
         end

         ST_RESP: begin
            if (!we_q) begin
               rdata_d = ram_rdata;
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wid_q      <= RID_IF;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         if_done_q  <= 1'b0;
         dm_done_q  <= 1'b0;
         dbg_done_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         wid_q      <= wid_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         ram_en_q   <= ram_en_d;
         ram_we_q   <= ram_we_d;
         if_done_q  <= if_done_d;
         dm_done_q  <= dm_done_d;
         dbg_done_q <= dbg_done_d;
         rdata_q    <= rdata_d;
      end
   end

   // RAM data arrives during RESP, so reads forward it straight through.
   assign rdata_out = (state_q == ST_RESP && !we_q) ? ram_rdata : rdata_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign if_done   = if_done_q;
   assign dm_done   = dm_done_q;
   assign dbg_done  = dbg_done_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 1-cycle block RAM.
module tb_mem_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam logic [1:0] ID_IF  = 2'd0;
   localparam logic [1:0] ID_DM  = 2'd1;
   localparam logic [1:0] ID_DBG = 2'd2;

   typedef struct packed {
      logic [1:0]    id;
      logic          rd;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dbg_req = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0, dbg_addr = '0;
   logic [DW-1:0] dm_wdata = '0, dbg_wdata = '0;
   logic          if_done, dm_done, dbg_done, ram_en, ram_we, busy;
   logic [DW-1:0] rdata_out, ram_wdata;
   logic [DW-1:0] ram_rdata = '0;
   logic [AW-1:0] ram_addr;

   logic [DW-1:0] ram_mem [0:(1<<AW)-1];
   logic [DW-1:0] shadow  [0:(1<<AW)-1];
   exp_t          exp_q[$];
   int            done_cyc_q[$];
   logic [DW-1:0] model_last = '0;
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .if_done(if_done), .dm_done(dm_done), .dbg_done(dbg_done),
      .rdata_out(rdata_out),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   // Read-first synchronous RAM.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         ram_rdata <= ram_mem[ram_addr];
      end
   end

   // Scoreboard: every done pulse pops the oldest expectation.
   always @(negedge clk) begin
      int nd;
      nd = int'(if_done) + int'(dm_done) + int'(dbg_done);
      if (nd != 0) begin
         logic [1:0] oid;
         exp_t       e;
         oid = dbg_done ? ID_DBG : (dm_done ? ID_DM : ID_IF);
         done_cyc_q.push_back(cyc);
         n_checks++;
         if (nd > 1) begin
            n_fail++;
            $display("FAIL done_onehot: %0d done pulses high, required at most 1", nd);
         end
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: done from id %0d, required no done", oid);
         end else begin
            e = exp_q.pop_front();
            if (oid !== e.id) begin
               n_fail++;
               $display("FAIL sb_order: done id %0d, required id %0d", oid, e.id);
            end
            n_checks++;
            if (e.rd) begin
               if (rdata_out !== e.data) begin
                  n_fail++;
                  $display("FAIL sb_rdata: rdata_out %h, required %h", rdata_out, e.data);
               end
               model_last = e.data;
            end else if (rdata_out !== model_last) begin
               n_fail++;
               $display("FAIL sb_write_hold: rdata_out %h, required %h", rdata_out, model_last);
            end
         end
      end
      if (ram_en) begin
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL en_outside_access: ram_en 1 with busy %b, required busy 1", busy);
         end
      end
   end

   task automatic push(input logic [1:0] id, input logic rd, input logic [DW-1:0] d);
      exp_t e;
      e.id = id; e.rd = rd; e.data = d;
      exp_q.push_back(e);
   endtask

   // Waits for n done pulses, dropping each served request like a requester would.
   task automatic wait_dones(input int n, input bit keep_if, input int budget);
      int seen = 0;
      int t = 0;
      while (seen < n && t < budget) begin
         @(negedge clk);
         t++;
         if (dbg_done) begin dbg_req = 1'b0; seen++; end
         if (dm_done)  begin dm_req  = 1'b0; seen++; end
         if (if_done)  begin if (!keep_if) if_req = 1'b0; seen++; end
      end
      #1;
      if (seen < n) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: %0d done pulses seen, required %0d", seen, n);
      end
   endtask

   task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
      push(ID_DBG, 1'b0, '0);
      shadow[a] = d;
      wait_dones(1, 1'b0, 10);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ram_en, ram_we, if_done, dm_done, dbg_done, busy} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: en/we/done x3/busy %b, required 000000",
                  {ram_en, ram_we, if_done, dm_done, dbg_done, busy});
      end
      n_checks++;
      if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: %h, required 0", ram_addr); end
      n_checks++;
      if (ram_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: %h, required 0", ram_wdata); end
      n_checks++;
      if (rdata_out !== '0) begin n_fail++; $display("FAIL reset_rdata: %h, required 0", rdata_out); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: busy %b, required 0", busy); end
   endtask

   task automatic test_load;
      dbg_write(10'h004, 32'h20080005);
      dbg_write(10'h0AA, 32'h0BADC0DE);
      dbg_write(10'h3FF, 32'h13579BDF);
      n_checks++;
      if (ram_mem[10'h004] !== 32'h20080005) begin
         n_fail++;
         $display("FAIL load_ram4: RAM[4] %h, required 20080005", ram_mem[10'h004]);
      end
   endtask

   task automatic test_fetch;
      int start;
      done_cyc_q.delete();
      @(posedge clk); #1;
      if_addr = 10'h004; if_req = 1'b1;
      push(ID_IF, 1'b1, shadow[10'h004]);
      start = cyc;
      @(negedge clk);
      n_checks++;
      if ({ram_en, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL fetch_cycle1: ram_en/busy %b, required 00", {ram_en, busy});
      end
      @(negedge clk);
      n_checks++;
      if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 10'h004}) begin
         n_fail++;
         $display("FAIL fetch_access: en %b we %b addr %h, required 1 0 004", ram_en, ram_we, ram_addr);
      end
      wait_dones(1, 1'b0, 10);
      n_checks++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] - start != 2) begin
         n_fail++;
         $display("FAIL fetch_latency: done %0d cycles after request cycle, required 2",
                  done_cyc_q.size() > 0 ? done_cyc_q[0] - start : -1);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (rdata_out !== 32'h20080005) begin
         n_fail++;
         $display("FAIL fetch_hold: rdata_out %h, required 20080005", rdata_out);
      end
   endtask

   task automatic test_dm_write_read;
      @(posedge clk); #1;
      dm_addr = 10'h010; dm_wdata = 32'hDEADBEEF; dm_we = 1'b1; dm_req = 1'b1;
      push(ID_DM, 1'b0, '0);
      shadow[10'h010] = 32'hDEADBEEF;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 10'h010, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL dm_write_access: en %b we %b addr %h wdata %h, required 1 1 010 deadbeef",
                  ram_en, ram_we, ram_addr, ram_wdata);
      end
      wait_dones(1, 1'b0, 10);
      @(posedge clk); #1;
      dm_we = 1'b0; dm_req = 1'b1;
      push(ID_DM, 1'b1, shadow[10'h010]);
      wait_dones(1, 1'b0, 10);
   endtask

   task automatic test_priority;
      done_cyc_q.delete();
      @(posedge clk); #1;
      dbg_addr = 10'h020; dbg_wdata = 32'h12345678; dbg_req = 1'b1;
      dm_addr = 10'h010; dm_we = 1'b0; dm_req = 1'b1;
      if_addr = 10'h020; if_req = 1'b1;
      push(ID_DBG, 1'b0, '0);
      shadow[10'h020] = 32'h12345678;
      push(ID_DM, 1'b1, shadow[10'h010]);
      push(ID_IF, 1'b1, shadow[10'h020]);
      wait_dones(3, 1'b0, 30);
      n_checks++;
      if (done_cyc_q.size() != 3 || done_cyc_q[1] - done_cyc_q[0] != 3 ||
          done_cyc_q[2] - done_cyc_q[1] != 3) begin
         n_fail++;
         $display("FAIL prio_spacing: %0d dones, gaps %0d %0d, required 3 dones with gaps 3 3",
                  done_cyc_q.size(), done_cyc_q[1] - done_cyc_q[0], done_cyc_q[2] - done_cyc_q[1]);
      end
   endtask

   task automatic test_addr_capture;
      @(posedge clk); #1;
      if_addr = 10'h0AA; if_req = 1'b1;
      push(ID_IF, 1'b1, shadow[10'h0AA]);
      @(posedge clk); #1;
      if_addr = 10'h3FF;
      @(negedge clk);
      n_checks++;
      if (ram_addr !== 10'h0AA) begin
         n_fail++;
         $display("FAIL addr_latched: ram_addr %h, required 0aa", ram_addr);
      end
      wait_dones(1, 1'b0, 10);
      @(posedge clk); #1;
      if_req = 1'b1;
      push(ID_IF, 1'b1, shadow[10'h3FF]);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ram_en, ram_addr} !== {1'b1, 10'h3FF}) begin
         n_fail++;
         $display("FAIL addr_top: en %b addr %h, required 1 3ff", ram_en, ram_addr);
      end
      wait_dones(1, 1'b0, 10);
   endtask

   task automatic test_reset_abort;
      @(posedge clk); #1;
      dm_addr = 10'h010; dm_we = 1'b0; dm_req = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_last = '0;
      @(negedge clk);
      n_checks++;
      if ({ram_en, ram_we, if_done, dm_done, dbg_done, busy} !== 6'b0) begin
         n_fail++;
         $display("FAIL abort_ctrl: en/we/done x3/busy %b, required 000000",
                  {ram_en, ram_we, if_done, dm_done, dbg_done, busy});
      end
      n_checks++;
      if ({ram_addr, ram_wdata, rdata_out} !== '0) begin
         n_fail++;
         $display("FAIL abort_data: addr %h wdata %h rdata %h, required all 0",
                  ram_addr, ram_wdata, rdata_out);
      end
      push(ID_DM, 1'b1, shadow[10'h010]);
      wait_dones(1, 1'b0, 10);
   endtask

   task automatic test_back_to_back;
      done_cyc_q.delete();
      @(posedge clk); #1;
      if_addr = 10'h004; if_req = 1'b1;
      push(ID_IF, 1'b1, shadow[10'h004]);
      push(ID_IF, 1'b1, shadow[10'h004]);
      push(ID_DBG, 1'b0, '0);
      push(ID_IF, 1'b1, shadow[10'h004]);
      shadow[10'h030] = 32'hCAFEF00D;
      fork
         begin
            repeat (4) @(posedge clk);
            #1;
            dbg_addr = 10'h030; dbg_wdata = 32'hCAFEF00D; dbg_req = 1'b1;
         end
         wait_dones(4, 1'b1, 40);
      join
      if_req = 1'b0;
      n_checks++;
      if (done_cyc_q.size() != 4 || done_cyc_q[3] - done_cyc_q[0] != 9) begin
         n_fail++;
         $display("FAIL b2b_spacing: %0d dones spanning %0d cycles, required 4 spanning 9",
                  done_cyc_q.size(), done_cyc_q[3] - done_cyc_q[0]);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, busy %b, required 0 and 0", exp_q.size(), busy);
      end
      n_checks++;
      if (ram_mem[10'h030] !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL b2b_dbg_write: RAM[030] %h, required cafef00d", ram_mem[10'h030]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load();
      test_fetch();
      test_dm_write_read();
      test_priority();
      test_addr_capture();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word address width of the shared block RAM.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request, level, held until if_done.
REQ-006 if_addr  input  ADDR_W  fetch word address.
REQ-007 dm_req  input  1  data-memory request (MEM phase), level, held until dm_done.
REQ-008 dm_we  input  1  1 = write, 0 = read, for the dm request.
REQ-009 dm_addr / dm_wdata  input  ADDR_W / DATA_W  data address and write data.
REQ-010 dbg_req  input  1  program-loader write request, level, held until dbg_done.
REQ-011 dbg_addr / dbg_wdata  input  ADDR_W / DATA_W  loader address and data (always write).
REQ-012 if_done / dm_done / dbg_done  output  1 each  one-cycle completion pulse per requester.
REQ-013 rdata_out  output  DATA_W  read data, valid in the cycle if_done or dm_done (read) is high.
REQ-014 ram_en / ram_we  output  1 / 1  block-RAM port enable and write enable.
REQ-015 ram_addr / ram_wdata  output  ADDR_W / DATA_W  block-RAM port address and write data.
REQ-016 ram_rdata  input  DATA_W  block-RAM read data, 1-cycle synchronous latency after ram_en.
REQ-017 busy  output  1  high while in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-019 IDLE: on any request, the FSM SHALL latch the winner (priority dbg > dm > if) and go to ACCESS next cycle; with no request it SHALL stay in IDLE.
REQ-020 ACCESS (one cycle): the block SHALL drive ram_en=1, ram_addr/ram_wdata from the latched winner, ram_we=1 for dbg or dm writes, else 0; it SHALL go to RESP.
REQ-021 RESP (one cycle): the block SHALL pulse the winner's done output, drive rdata_out=ram_rdata for reads, and return to IDLE.
REQ-022 Transaction latency SHALL be 3 cycles, request sampled to done pulse, for an uncontended request.
REQ-023 Address, data and we SHALL be captured into registers at the IDLE->ACCESS transition; later input changes SHALL NOT affect the transaction in flight.
REQ-024 Requests arriving during ACCESS or RESP SHALL wait; arbitration occurs only in IDLE.
REQ-025 Simultaneous requests SHALL be served strictly by priority, one per transaction; the loser remains pending and wins the next arbitration if still highest.
REQ-026 A requester that deasserts its req before its done SHALL still have its transaction complete (done pulse ignored by the requester).
REQ-027 At most one done output SHALL be high in any cycle; ram_en SHALL be high only in ACCESS.
REQ-028 rdata_out SHALL hold its last value outside RESP; on writes it SHALL NOT change.
REQ-029 Outputs ram_en, ram_we and all done SHALL be registered (no combinational path from any req).

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL enter IDLE, and ram_en, ram_we, all done outputs, busy SHALL be 0, ram_addr, ram_wdata, rdata_out SHALL be 0.
REQ-031 Reset asserted in ACCESS or RESP SHALL abort the transaction with no done pulse; a RAM write issued in that ACCESS cycle is not rolled back.
REQ-032 Reset SHALL take priority over all requests in the same cycle.

Structure
REQ-033 State encodings (IDLE, ACCESS, RESP), requester IDs and ADDR_W/DATA_W defaults SHALL live in a shared package.
REQ-034 The block SHALL be one module; no sub-module is required, the block RAM is instantiated outside it.

Verification
REQ-035 if_req=1, if_addr=0x004, RAM[4]=0x20080005 -> ram_en high cycle 2, if_done and rdata_out=0x20080005 cycle 3.
REQ-036 dm_req=1, dm_we=1, dm_addr=0x010, dm_wdata=0xDEADBEEF -> ram_we=1 in ACCESS, dm_done cycle 3, subsequent dm read of 0x010 returns 0xDEADBEEF.
REQ-037 if_req, dm_req (read) and dbg_req raised same cycle -> dbg_done, then dm_done, then if_done, each 3 cycles apart, never overlapping.
REQ-038 if_req granted, if_addr changed to 0x3FF during ACCESS -> ram_addr stays at the latched value, wraps correctly at 0x3FF on the next request.
REQ-039 rst pulsed during ACCESS of a dm read -> no dm_done, all outputs 0 next cycle, state IDLE, held dm_req re-served from IDLE.
REQ-040 Continuous if_req with dbg_req at cycle 5 -> dbg served at the next IDLE, fetch resumes after, no cycle with two done pulses.
